inst_encoder: RTL
=================

# inst_encoder

Packs decoded instruction fields back into a 32-bit RV32I instruction word: the inverse of the immediate generator in the decode stage. It accepts opcode, register, funct and sign-extended immediate fields over a valid/ready handshake. It range-checks the immediate for the opcode's format and emits the encoded word from a registered, back-pressurable output stage. It sits in the debug/boot-loader path, which synthesizes instructions for injection into fetch, and in self-check benches as the round-trip partner of `imm_gen`.

## Interface
- `DATA_WIDTH`, from `my_pkg` (32): instruction and immediate width.
- `CNT_WIDTH`, 16: width of the statistics counters.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  field bundle valid.
- `in_ready`  out  1  encoder can accept this cycle.
- `in_opcode`  in  7  opcode; selects the format.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_funct3`  in  3  funct3.
- `in_funct7`  in  7  funct7 (R format only).
- `in_imm`  in  DATA_WIDTH  sign-extended immediate, in the same form `imm_gen` produces.
- `out_valid`  out  1  encoded word valid.
- `out_ready`  in  1  consumer accepts.
- `out_inst`  out  DATA_WIDTH  encoded instruction; 0 when `out_err` is 1.
- `out_err`  out  1  bundle was not encodable.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `enc_cnt`  out  CNT_WIDTH  accepted bundles that encoded without error; wraps.
- `err_cnt`  out  CNT_WIDTH  accepted bundles that errored; saturates at all-ones.

## Operation
- **Format by opcode**
  - R: 0110011.
  - I: 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode sets the error.
- **Packing** (bit 31 first):
  - R: funct7 | rs2 | rs1 | f3 | rd | op.
  - I: imm[11:0] | rs1 | f3 | rd | op.
  - S: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | op.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | op.
  - U: imm[31:12] | rd | op.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op.
  - Fields unused by a format are ignored.
- **Immediate legality.** Any failure sets the error.
  - I/S: imm[31:11] all equal.
  - B: imm[0] == 0 and imm[31:12] all equal.
  - U: imm[11:0] == 0.
  - J: imm[0] == 0 and imm[31:20] all equal.
  - R: imm ignored.
- **Round-trip invariant.** For every non-error output, `imm_gen(out_inst) == in_imm`. R format is excluded: `imm_gen` returns 0.
- **Handshake and output register.**
  - Single output register; `in_ready = !out_valid || out_ready`.
  - An input is accepted when `in_valid && in_ready`. `out_inst`, `out_err` and `out_valid=1` load on that edge.
  - The output is dropped when `out_valid && out_ready` and no new accept occurs.
  - While `out_valid && !out_ready`, `out_inst` and `out_err` hold stable.
- **Counters.**
  - On accept: `enc_cnt` += 1 (wraps modulo 2^CNT_WIDTH) if no error; otherwise `err_cnt` += 1 unless it is already all-ones.
  - `cnt_clr` zeroes both counters. When it coincides with an accept, the clear wins and that accept is not counted.

## Timing
- Reset (asynchronous, any cycle including mid-transfer): `out_valid`=0, `out_inst`=0, `out_err`=0, `enc_cnt`=0, `err_cnt`=0. An in-flight output is discarded.
- `in_ready` is 1 combinationally from the first cycle after reset.
- Latency is 1 cycle: a bundle accepted at edge N is visible at the outputs after edge N.
- Throughput is 1 bundle per cycle while `out_ready` is held high. Simultaneous drain and accept in the same cycle replaces the output with no bubble.
- There is no combinational path from `in_*` to `out_*`. `in_ready` depends only on `out_valid` and `out_ready`.

## Test plan
- **I format.** opcode 0010011, rd=1, rs1=2, f3=0, imm=0xFFFFFFFF (`addi x1,x2,-1`) → next cycle `out_inst`=0xFFF10093, `out_err`=0, `enc_cnt`=1.
- **B format.** opcode 1100011, rs1=rs2=0, f3=0, imm=0xFFFFFFFC (`beq x0,x0,-4`) → 0xFE000EE3. Repeat with imm=3 → `out_err`=1, `out_inst`=0, `err_cnt`=1.
- **U format and bad opcode.** opcode 0110111, rd=5, imm=0x12345000 → 0x123452B7. Repeat with imm=0x12345001 → error. Opcode 1111111 → error.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles with `in_valid`=1 → exactly one accept, `in_ready`=0 from the second cycle, `out_inst` stable. Then raise `out_ready` → one word per cycle, none lost or duplicated.
- **Counters and reset.** Accept `cnt_clr` in the same cycle as a valid bundle → both counters read 0 afterward. Force `err_cnt` to saturation → it stays 0xFFFF. Assert `rst_n` low while `out_valid`=1 → all outputs are 0 immediately.
- **Round trip.** 10k random legal bundles across all formats, with the output fed through `imm_gen` → the decoded imm equals `in_imm` for every non-R word.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields (opcode, regs, functs, sign-extended
// immediate) into a 32-bit word behind a single back-pressurable output register.
package my_pkg;
    localparam int DATA_WIDTH = 32;
endpackage

module inst_encoder
    import my_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [DATA_WIDTH-1:0] in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  out_err,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  enc_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    fmt_e                  w_fmt;
    logic                  w_sext_11;
    logic                  w_sext_12;
    logic                  w_sext_20;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_inst;
    logic                  w_accept;

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_inst;
    logic                  r_out_err;
    logic [CNT_WIDTH-1:0]  r_enc_cnt;
    logic [CNT_WIDTH-1:0]  r_err_cnt;

    always_comb begin
        unique case (in_opcode)
            7'b0110011:                         w_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: w_fmt = FMT_I;
            7'b0100011:                         w_fmt = FMT_S;
            7'b1100011:                         w_fmt = FMT_B;
            7'b0110111, 7'b0010111:             w_fmt = FMT_U;
            7'b1101111:                         w_fmt = FMT_J;
            default:                            w_fmt = FMT_BAD;
        endcase
    end

    // An immediate fits a signed field of width k+1 when bits [31:k] are all copies of the sign.
    assign w_sext_11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_sext_12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_sext_20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_err  = 1'b0;
        w_inst = '0;
        case (w_fmt)
            FMT_R: w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: begin
                w_err  = ~w_sext_11;
                w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            end
            FMT_S: begin
                w_err  = ~w_sext_11;
                w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            end
            FMT_B: begin
                w_err  = in_imm[0] | ~w_sext_12;
                w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
            end
            FMT_U: begin
                w_err  = |in_imm[11:0];
                w_inst = {in_imm[31:12], in_rd, in_opcode};
            end
            FMT_J: begin
                w_err  = in_imm[0] | ~w_sext_20;
                w_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            end
            default: w_err = 1'b1;
        endcase
        if (w_err) begin
            w_inst = '0;
        end
    end

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= w_inst;
            r_out_err   <= w_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // A clear coinciding with an accept wins; the accepted bundle is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (cnt_clr) begin
            r_enc_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_accept) begin
            if (!w_err) begin
                r_enc_cnt <= r_enc_cnt + 1'b1;
            end else if (!(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_err   = r_out_err;
    assign enc_cnt   = r_enc_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
